// File: rtl/disp_scan_ctrl_pkg.sv
// disp_scan_ctrl_pkg: segment constants, hex-to-segment lookup and the
// glyph priority rule shared by the scan controller and its decoder.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package disp_scan_ctrl_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_ERR = 7'b0000110;

  typedef enum logic [1:0] {
    GLYPH_HEX   = 2'd0,
    GLYPH_ERR   = 2'd1,
    GLYPH_BLANK = 2'd2
  } glyph_e;

  // Active-low segment pattern for a hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Blank wins over error, error wins over the hex value.
  function automatic glyph_e glyph_sel(input logic blank, input logic err);
    glyph_e g;
    if (blank)    g = GLYPH_BLANK;
    else if (err) g = GLYPH_ERR;
    else          g = GLYPH_HEX;
    return g;
  endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// disp_scan_ctrl_if: digit data, load/ack handshake, brightness and the
// board-pin outputs of the scan controller. The blink mask exists only
// when DISP_BLINK_EN is defined.
interface disp_scan_ctrl_if #(
  parameter int N_DIGITS = 4,
  parameter int BRIGHT_W = 2
);
  logic [4*N_DIGITS-1:0] digits;
  logic [N_DIGITS-1:0]   error;
  logic [N_DIGITS-1:0]   dec_point;
  logic [N_DIGITS-1:0]   blank;
`ifdef DISP_BLINK_EN
  logic [N_DIGITS-1:0]   blink;
`endif
  logic                  load;
  logic [BRIGHT_W-1:0]   brightness;
  logic                  load_ack;
  logic                  frame_tick;
  logic [7:0]            seg_n;
  logic [N_DIGITS-1:0]   dig_n;

`ifdef DISP_BLINK_EN
  modport master (
    output digits, error, dec_point, blank, blink, load, brightness,
    input  load_ack, frame_tick, seg_n, dig_n
  );
  modport slave (
    input  digits, error, dec_point, blank, blink, load, brightness,
    output load_ack, frame_tick, seg_n, dig_n
  );
`else
  modport master (
    output digits, error, dec_point, blank, load, brightness,
    input  load_ack, frame_tick, seg_n, dig_n
  );
  modport slave (
    input  digits, error, dec_point, blank, load, brightness,
    output load_ack, frame_tick, seg_n, dig_n
  );
`endif

endinterface

// File: rtl/disp_scan_ctrl_seg7_decode.sv
// seg7_decode: combinational nibble/error/blank to 7-segment (active-low)
// decoder applying the blank > error > hex priority.
module seg7_decode
  import disp_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       error,
  input  logic       blank,
  output logic [6:0] seg
);

  // Select glyph by priority and look up its segment pattern.
  always_comb begin
    seg = SEG_OFF;
    case (glyph_sel(blank, error))
      GLYPH_BLANK: seg = SEG_OFF;
      GLYPH_ERR:   seg = SEG_ERR;
      default:     seg = hex_to_seg(nibble);
    endcase
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexed 7-segment scan controller.
// N_DIGITS digits, 2**SLOT_W clocks per digit slot, per-slot PWM brightness,
// double-buffered digit data with load/load_ack handshake.
// Optional feature macro: DISP_BLINK_EN (blink mask + frame counter).
module disp_scan_ctrl
  import disp_scan_ctrl_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int SLOT_W   = 16,
  parameter int BRIGHT_W = 2
`ifdef DISP_BLINK_EN
  ,
  parameter int BLINK_FR = 32
`endif
) (
  input  logic           clk,
  input  logic           reset,
  disp_scan_ctrl_if.slave bus
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [SLOT_W-1:0]     cnt;
  logic [IDX_W-1:0]      idx;
  logic                  slot_end;
  logic                  frame_end;

  logic [4*N_DIGITS-1:0] pend_digits;
  logic [N_DIGITS-1:0]   pend_error;
  logic [N_DIGITS-1:0]   pend_dp;
  logic [N_DIGITS-1:0]   pend_blank;
  logic                  pend_vld;
  logic                  apply;

  logic [4*N_DIGITS-1:0] act_digits;
  logic [N_DIGITS-1:0]   act_error;
  logic [N_DIGITS-1:0]   act_dp;
  logic [N_DIGITS-1:0]   act_blank;

  logic                  blink_kill;
  logic                  glyph_blank;
  logic [3:0]            cur_nib;
  logic [6:0]            seg_raw;
  logic                  dp_n;
  logic [BRIGHT_W-1:0]   pwm_top;
  logic                  lit;

  logic [7:0]            seg_n_p1;
  logic [N_DIGITS-1:0]   dig_n_p1;
  logic                  load_ack_p1;
  logic                  frame_tick_p1;

  assign slot_end  = &cnt;
  assign frame_end = slot_end && (idx == IDX_W'(N_DIGITS - 1));
  assign apply     = frame_end && pend_vld;

  // Slot counter and digit index; idx steps once per slot and wraps per frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (slot_end)
        idx <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  // Pending buffer data: last load wins until the next frame boundary.
  always_ff @(posedge clk) begin
    if (bus.load) begin
      pend_digits <= bus.digits;
      pend_error  <= bus.error;
      pend_dp     <= bus.dec_point;
      pend_blank  <= bus.blank;
    end
  end

  // Pending-valid flag; a load on the frame boundary stays pending for the next frame.
  always_ff @(posedge clk) begin
    if (reset)
      pend_vld <= 1'b0;
    else if (bus.load)
      pend_vld <= 1'b1;
    else if (frame_end)
      pend_vld <= 1'b0;
  end

  // Active buffer: swapped in only at a frame wrap so a frame never tears.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_blank <= '1;
    end else if (apply) begin
      act_digits <= pend_digits;
      act_error  <= pend_error;
      act_dp     <= pend_dp;
      act_blank  <= pend_blank;
    end
  end

`ifdef DISP_BLINK_EN
  localparam int FR_W = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;

  logic [N_DIGITS-1:0] pend_blink;
  logic [N_DIGITS-1:0] act_blink;
  logic [FR_W-1:0]     fr_cnt;
  logic                phase;

  // Blink mask travels with the rest of the digit data.
  always_ff @(posedge clk) begin
    if (bus.load)
      pend_blink <= bus.blink;
  end

  // Active blink mask, cleared by reset so nothing blinks before a load.
  always_ff @(posedge clk) begin
    if (reset)
      act_blink <= '0;
    else if (apply)
      act_blink <= pend_blink;
  end

  // Frame counter toggling the blink phase every BLINK_FR frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      fr_cnt <= '0;
      phase  <= 1'b0;
    end else if (frame_end) begin
      if (fr_cnt == FR_W'(BLINK_FR - 1)) begin
        fr_cnt <= '0;
        phase  <= ~phase;
      end else begin
        fr_cnt <= fr_cnt + 1'b1;
      end
    end
  end

  assign blink_kill = phase & act_blink[idx];
`else
  assign blink_kill = 1'b0;
`endif

  assign glyph_blank = act_blank[idx] | blink_kill;
  assign cur_nib     = act_digits[{idx, 2'b00} +: 4];
  assign dp_n        = glyph_blank | ~act_dp[idx];

  seg7_decode u_dec (
    .nibble (cur_nib),
    .error  (act_error[idx]),
    .blank  (glyph_blank),
    .seg    (seg_raw)
  );

  // PWM window: compare the top slot-counter bits against the live brightness.
  assign pwm_top = cnt[SLOT_W-1 -: BRIGHT_W];
  assign lit     = (&bus.brightness) || (pwm_top < bus.brightness);

  // Pin register: segments and digit enables change on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_n_p1 <= 8'hFF;
      dig_n_p1 <= '1;
    end else if (lit) begin
      seg_n_p1 <= {dp_n, seg_raw};
      dig_n_p1 <= ~(N_DIGITS'(1) << idx);
    end else begin
      seg_n_p1 <= 8'hFF;
      dig_n_p1 <= '1;
    end
  end

  // Single-cycle status pulses, one cycle after the frame boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_ack_p1   <= 1'b0;
      frame_tick_p1 <= 1'b0;
    end else begin
      load_ack_p1   <= apply;
      frame_tick_p1 <= frame_end;
    end
  end

  assign bus.seg_n      = seg_n_p1;
  assign bus.dig_n      = dig_n_p1;
  assign bus.load_ack   = load_ack_p1;
  assign bus.frame_tick = frame_tick_p1;

endmodule
